enc_8b10b_lanes: RTL and testbench

ENC_8B10B_LANES -- requirements
Module: enc_8b10b_lanes

---
 rtl/enc_8b10b_lanes.sv | 154 +++++++++++++++
 tb/tb_enc_8b10b_lanes.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_8b10b_lanes.sv
// Multi-lane 8B/10B encoder with running disparity chained lane 0 -> LANES-1 and a one-deep output register.
// Optional ENC8B10B_KCHECK_EN adds a per-lane illegal-K flag (k_err) aligned with out_data.
module enc_8b10b_lanes #(
    parameter int   LANES   = 2,
    parameter logic RD_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
    input  logic                  rd_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic                  out_rd
`ifdef ENC8B10B_KCHECK_EN
    , output logic [LANES-1:0]    k_err
`endif
);

    // 5B/6B codes for RD-, written abcdei with a as the MSB.
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3B/4B data codes for RD-, written fghj with f as the MSB (primary D.x.7).
    function automatic logic [3:0] tbl4(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;  default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // Returns {rd_after, symbol}; symbol bit 0 is a, bit 9 is j.
    function automatic logic [10:0] enc_byte(input logic [7:0] d, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       unbal6, unbal4, rd_mid, a7, neutral_y;
        logic [9:0] sym;
        x = d[4:0];
        y = d[7:5];
        c6 = (k && x == 5'd28) ? 6'b001111 : tbl6(x);
        unbal6 = ($countones(c6) != 3);
        if (rd && (unbal6 || x == 5'd7)) c6 = ~c6;
        rd_mid = rd ^ unbal6;
        a7 = (y == 3'd7) && (k ||
             (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        c4 = a7 ? 4'b0111 : tbl4(y);
        neutral_y = (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6);
        // Control characters use the inverted neutral codes so that they alternate with RD.
        if (k && neutral_y) c4 = ~c4;
        unbal4 = ($countones(c4) != 2);
        if (rd_mid && (unbal4 || y == 3'd3 || (k && neutral_y))) c4 = ~c4;
        for (int i = 0; i < 6; i++) sym[i] = c6[5-i];
        for (int i = 0; i < 4; i++) sym[6+i] = c4[3-i];
        return {rd_mid ^ unbal4, sym};
    endfunction

    logic                  out_valid_q;
    logic [10*LANES-1:0]   out_data_q, out_data_d;
    logic                  out_rd_q;
    logic                  rd_q, rd_d;
    logic                  rd_run;
    logic [10:0]           lane_res;
    logic                  xfer;

    assign in_ready  = !out_valid_q | out_ready;
    assign xfer      = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;

    always_comb begin
        out_data_d = '0;
        lane_res   = '0;
        rd_run     = rd_clr ? RD_INIT : rd_q;
        for (int n = 0; n < LANES; n++) begin
            lane_res = enc_byte(in_data[8*n +: 8], in_k[n], rd_run);
            out_data_d[10*n +: 10] = lane_res[9:0];
            rd_run = lane_res[10];
        end
        rd_d = rd_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= RD_INIT;
            rd_q        <= RD_INIT;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_rd_q    <= rd_d;
            rd_q        <= rd_d;
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            if (rd_clr)    rd_q        <= RD_INIT;
        end
    end

`ifdef ENC8B10B_KCHECK_EN
    // Legal controls: K28.0-7, K23.7, K27.7, K29.7, K30.7.
    function automatic logic k_legal(input logic [7:0] d);
        return (d[4:0] == 5'd28) ||
               (d[7:5] == 3'd7 && (d[4:0] == 5'd23 || d[4:0] == 5'd27 ||
                                   d[4:0] == 5'd29 || d[4:0] == 5'd30));
    endfunction

    logic [LANES-1:0] k_err_q, k_err_d;

    always_comb begin
        k_err_d = '0;
        for (int n = 0; n < LANES; n++)
            k_err_d[n] = in_k[n] && !k_legal(in_data[8*n +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    k_err_q <= '0;
        else if (xfer) k_err_q <= k_err_d;
    end

    assign k_err = k_err_q;
`endif

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
// Directed bench for enc_8b10b_lanes: one LANES=1 and one LANES=2 instance on a shared clock and reset.
// Build with ENC8B10B_KCHECK_EN defined to also exercise k_err.
module tb_enc_8b10b_lanes;

    logic clk;
    logic rst_n;

    logic        l1_in_valid, l1_in_ready, l1_in_k, l1_rd_clr;
    logic [7:0]  l1_in_data;
    logic        l1_out_valid, l1_out_ready, l1_out_rd;
    logic [9:0]  l1_out_data;

    logic        l2_in_valid, l2_in_ready, l2_rd_clr;
    logic [1:0]  l2_in_k;
    logic [15:0] l2_in_data;
    logic        l2_out_valid, l2_out_ready, l2_out_rd;
    logic [19:0] l2_out_data;

`ifdef ENC8B10B_KCHECK_EN
    logic [0:0]  l1_k_err;
    logic [1:0]  l2_k_err;
`endif

    int checks;
    int errors;

    logic [19:0] exp_q[$];
    logic        exp_rd_q[$];

    enc_8b10b_lanes #(.LANES(1), .RD_INIT(1'b0)) u_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (l1_in_valid),
        .in_ready  (l1_in_ready),
        .in_data   (l1_in_data),
        .in_k      (l1_in_k),
        .rd_clr    (l1_rd_clr),
        .out_valid (l1_out_valid),
        .out_ready (l1_out_ready),
        .out_data  (l1_out_data),
        .out_rd    (l1_out_rd)
`ifdef ENC8B10B_KCHECK_EN
        , .k_err   (l1_k_err)
`endif
    );

    enc_8b10b_lanes #(.LANES(2), .RD_INIT(1'b0)) u_l2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (l2_in_valid),
        .in_ready  (l2_in_ready),
        .in_data   (l2_in_data),
        .in_k      (l2_in_k),
        .rd_clr    (l2_rd_clr),
        .out_valid (l2_out_valid),
        .out_ready (l2_out_ready),
        .out_data  (l2_out_data),
        .out_rd    (l2_out_rd)
`ifdef ENC8B10B_KCHECK_EN
        , .k_err   (l2_k_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one word to the LANES=1 instance; returns #1 after the accepting edge.
    task automatic l1_step(input logic [7:0] d, input logic k, input logic clr);
        l1_in_data  = d;
        l1_in_k     = k;
        l1_rd_clr   = clr;
        l1_in_valid = 1'b1;
        @(posedge clk);
        #1;
        l1_in_valid = 1'b0;
        l1_rd_clr   = 1'b0;
    endtask

    initial begin
        logic [15:0] l2_words [3];
        logic [1:0]  l2_ks    [3];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        l1_in_valid = 1'b0; l1_in_data = '0; l1_in_k = 1'b0; l1_rd_clr = 1'b0; l1_out_ready = 1'b1;
        l2_in_valid = 1'b0; l2_in_data = '0; l2_in_k = '0;   l2_rd_clr = 1'b0; l2_out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", {31'd0, l1_out_valid}, 32'd0);
        check_eq("rst_out_data",  {22'd0, l1_out_data}, 32'd0);
        check_eq("rst_out_rd",    {31'd0, l1_out_rd}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, l1_in_ready}, 32'd1);
        check_eq("rst_l2_valid",  {31'd0, l2_out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // K28.5 alternation from RD-
        l1_step(8'hBC, 1'b1, 1'b0);
        check_eq("k285_a_valid", {31'd0, l1_out_valid}, 32'd1);
        check_eq("k285_a_data",  {22'd0, l1_out_data}, 32'h17C);
        check_eq("k285_a_rd",    {31'd0, l1_out_rd}, 32'd1);
        l1_step(8'hBC, 1'b1, 1'b0);
        check_eq("k285_b_data",  {22'd0, l1_out_data}, 32'h283);
        check_eq("k285_b_rd",    {31'd0, l1_out_rd}, 32'd0);
        @(posedge clk); #1;
        check_eq("idle_valid_clr", {31'd0, l1_out_valid}, 32'd0);

        // D0.0 at RD-, then a five-cycle stall with a K28.5 waiting
        l1_step(8'h00, 1'b0, 1'b0);
        check_eq("d00_data", {22'd0, l1_out_data}, 32'h0B9);
        check_eq("d00_rd",   {31'd0, l1_out_rd}, 32'd0);
        l1_out_ready = 1'b0;
        l1_in_data = 8'hBC; l1_in_k = 1'b1; l1_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall_data",  {22'd0, l1_out_data}, 32'h0B9);
            check_eq("stall_valid", {31'd0, l1_out_valid}, 32'd1);
            check_eq("stall_rd",    {31'd0, l1_out_rd}, 32'd0);
            check_eq("stall_ready", {31'd0, l1_in_ready}, 32'd0);
        end
        l1_out_ready = 1'b1;
        @(posedge clk); #1;
        l1_in_valid = 1'b0;
        check_eq("post_stall_data", {22'd0, l1_out_data}, 32'h17C);
        check_eq("post_stall_rd",   {31'd0, l1_out_rd}, 32'd1);

        // rd_clr on a transfer: RD+ is overridden, lane encodes from RD-
        l1_step(8'hBC, 1'b1, 1'b1);
        check_eq("clr_xfer_data", {22'd0, l1_out_data}, 32'h17C);
        check_eq("clr_xfer_rd",   {31'd0, l1_out_rd}, 32'd1);
        l1_step(8'h00, 1'b0, 1'b0);
        check_eq("d00_rdp_data", {22'd0, l1_out_data}, 32'h346);
        check_eq("d00_rdp_rd",   {31'd0, l1_out_rd}, 32'd1);

        // rd_clr with no transfer
        l1_rd_clr = 1'b1;
        @(posedge clk); #1;
        l1_rd_clr = 1'b0;
        l1_step(8'hBC, 1'b1, 1'b0);
        check_eq("clr_idle_data", {22'd0, l1_out_data}, 32'h17C);

        // Reset while stalled
        l1_out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_valid", {31'd0, l1_out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, l1_out_valid}, 32'd0);
        check_eq("async_rst_data",  {22'd0, l1_out_data}, 32'd0);
        check_eq("async_rst_rd",    {31'd0, l1_out_rd}, 32'd0);
        check_eq("async_rst_ready", {31'd0, l1_in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        l1_out_ready = 1'b1;
        l1_step(8'hBC, 1'b1, 1'b0);
        check_eq("after_rst_data", {22'd0, l1_out_data}, 32'h17C);

        // D17.7: alternate code at RD-, primary at RD+
        l1_step(8'hF1, 1'b0, 1'b1);
        check_eq("d177_a7_data", {22'd0, l1_out_data}, 32'h3B1);
        check_eq("d177_a7_rd",   {31'd0, l1_out_rd}, 32'd1);
        l1_step(8'hF1, 1'b0, 1'b0);
        check_eq("d177_p7_data", {22'd0, l1_out_data}, 32'h231);
        check_eq("d177_p7_rd",   {31'd0, l1_out_rd}, 32'd0);

`ifdef ENC8B10B_KCHECK_EN
        l1_step(8'h00, 1'b1, 1'b0);
        check_eq("kerr_illegal", {31'd0, l1_k_err}, 32'd1);
        l1_step(8'hBC, 1'b1, 1'b0);
        check_eq("kerr_legal",   {31'd0, l1_k_err}, 32'd0);
`endif

        // Two-lane back-to-back stream, disparity chained across lanes and words
        l2_words[0] = 16'hB5BC; l2_ks[0] = 2'b01;
        l2_words[1] = 16'hBCBC; l2_ks[1] = 2'b11;
        l2_words[2] = 16'h0000; l2_ks[2] = 2'b00;
        exp_q.push_back(20'h5557C); exp_rd_q.push_back(1'b1);
        exp_q.push_back(20'h5F283); exp_rd_q.push_back(1'b1);
        exp_q.push_back(20'hD1B46); exp_rd_q.push_back(1'b1);
        l2_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [19:0] exp_d;
            logic        exp_r;
            l2_in_data = l2_words[i];
            l2_in_k    = l2_ks[i];
            @(posedge clk); #1;
            exp_d = exp_q.pop_front();
            exp_r = exp_rd_q.pop_front();
            check_eq("l2_valid", {31'd0, l2_out_valid}, 32'd1);
            check_eq("l2_data",  {12'd0, l2_out_data}, {12'd0, exp_d});
            check_eq("l2_rd",    {31'd0, l2_out_rd}, {31'd0, exp_r});
        end
        l2_in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("l2_idle_valid", {31'd0, l2_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
